// File: rtl/axis_pkt_gen.sv
// rtl/axis_pkt_gen.sv - AXI-Stream test packet generator with sequence-stamped payload
// Packets carry an incrementing byte pattern; beat 0 holds the sequence number and byte size.
module axis_pkt_gen #(
   parameter int TDATA_WIDTH = 512,
   parameter int TKEEP_WIDTH = 64,
   parameter int TUSER_WIDTH = 1
) (
   input  logic                   xdma_clk,
   input  logic                   xdma_reset,
   input  logic                   start,
   input  logic                   stop,
   input  logic [15:0]            pkt_size,
   input  logic [31:0]            pkt_interval,
   input  logic [31:0]            pkt_num,
   output logic                   m_axis_tvalid,
   input  logic                   m_axis_tready,
   output logic [TDATA_WIDTH-1:0] m_axis_tdata,
   output logic [TKEEP_WIDTH-1:0] m_axis_tkeep,
   output logic                   m_axis_tlast,
   output logic [TUSER_WIDTH-1:0] m_axis_tuser,
   output logic                   busy,
   output logic [31:0]            sent_pkt_count,
   output logic [31:0]            sent_beat_count
);

   typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

   state_t      state_q, state_d;
   logic [15:0] size_q, size_d;
   logic [31:0] interval_q, interval_d;
   logic [31:0] num_q, num_d;
   logic [31:0] gap_q, gap_d;
   logic [31:0] pkt_cnt_q, pkt_cnt_d;
   logic [31:0] beat_cnt_q, beat_cnt_d;
   logic [9:0]  beat_q, beat_d;
   logic        stop_pend_q, stop_pend_d;

   logic [15:0]            size_eff;
   logic [15:0]            size_m1;
   logic                   last_beat;
   logic [31:0]            pkt_cnt_inc;
   logic [TDATA_WIDTH-1:0] data_raw;
   logic [TKEEP_WIDTH-1:0] keep_last;

   // size_m1 gives both the last beat index and the last-beat byte count minus one
   assign size_eff    = (size_q == 16'd0) ? 16'd64 : size_q;
   assign size_m1     = size_eff - 16'd1;
   assign last_beat   = (beat_q == size_m1[15:6]);
   assign pkt_cnt_inc = pkt_cnt_q + 32'd1;

   always_comb begin
      data_raw  = '0;
      keep_last = '0;
      for (int i = 0; i < TKEEP_WIDTH; i++) begin
         data_raw[i*8 +: 8] = {beat_q[1:0], 6'(i)};
         keep_last[i]       = (6'(i) <= size_m1[5:0]);
      end
      if (beat_q == 10'd0) begin
         data_raw[31:0]  = pkt_cnt_q;
         data_raw[63:32] = {16'd0, size_eff};
      end
   end

   always_comb begin
      state_d     = state_q;
      size_d      = size_q;
      interval_d  = interval_q;
      num_d       = num_q;
      gap_d       = gap_q;
      pkt_cnt_d   = pkt_cnt_q;
      beat_cnt_d  = beat_cnt_q;
      beat_d      = beat_q;
      stop_pend_d = stop_pend_q;
      unique case (state_q)
         IDLE: begin
            if (start && !stop) begin
               size_d      = pkt_size;
               interval_d  = pkt_interval;
               num_d       = pkt_num;
               pkt_cnt_d   = 32'd0;
               beat_cnt_d  = 32'd0;
               beat_d      = 10'd0;
               stop_pend_d = 1'b0;
               state_d     = SEND;
            end
         end
         SEND: begin
            if (stop) stop_pend_d = 1'b1;
            if (m_axis_tready) begin
               beat_cnt_d = beat_cnt_q + 32'd1;
               if (last_beat) begin
                  pkt_cnt_d = pkt_cnt_inc;
                  beat_d    = 10'd0;
                  if ((num_q != 32'd0 && pkt_cnt_inc == num_q) || stop_pend_q || stop) begin
                     state_d     = IDLE;
                     stop_pend_d = 1'b0;
                  end else if (interval_q != 32'd0) begin
                     state_d = GAP;
                     gap_d   = interval_q - 32'd1;
                  end
               end else begin
                  beat_d = beat_q + 10'd1;
               end
            end
         end
         GAP: begin
            if (stop) begin
               state_d     = IDLE;
               stop_pend_d = 1'b0;
            end else if (gap_q == 32'd0) begin
               state_d = SEND;
            end else begin
               gap_d = gap_q - 32'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge xdma_clk) begin
      if (xdma_reset) begin
         state_q     <= IDLE;
         size_q      <= '0;
         interval_q  <= '0;
         num_q       <= '0;
         gap_q       <= '0;
         pkt_cnt_q   <= '0;
         beat_cnt_q  <= '0;
         beat_q      <= '0;
         stop_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         size_q      <= size_d;
         interval_q  <= interval_d;
         num_q       <= num_d;
         gap_q       <= gap_d;
         pkt_cnt_q   <= pkt_cnt_d;
         beat_cnt_q  <= beat_cnt_d;
         beat_q      <= beat_d;
         stop_pend_q <= stop_pend_d;
      end
   end

   // Stream outputs are pure decodes of registered state, so they hold during stalls
   assign m_axis_tvalid   = (state_q == SEND);
   assign m_axis_tlast    = (state_q == SEND) && last_beat;
   assign m_axis_tdata    = (state_q == SEND) ? data_raw : '0;
   assign m_axis_tkeep    = (state_q != SEND) ? '0 : (last_beat ? keep_last : '1);
   assign m_axis_tuser    = '0;
   assign busy            = (state_q != IDLE);
   assign sent_pkt_count  = pkt_cnt_q;
   assign sent_beat_count = beat_cnt_q;

endmodule
